// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer
// Multi-cycle controller for the shared RAM1 data bus (data SRAM + UART).
// Accepts one load/store from the MEM stage, decodes the address into SRAM,
// UART data or UART status, sequences the strobes and reports completion.
//
// Ports
//   CLK, RST                      clock (rising edge), async active-high reset
//   req, memRead, memWrite        request strobe and access type (write wins)
//   address, dataIn               word address and store data
//   dataOut                       load result, held until the next read
//   busy, done, timeout_err       status: in progress, 1-cycle completion,
//                                 sticky UART wait timeout
//   ram1OE, ram1WE, ram1EN        SRAM strobes (active-low)
//   ram1Addr, ram1Data            SRAM address and shared bidirectional bus
//   data_ready, tbre, tsre        UART status inputs
//   rdn, wrn                      UART strobes (active-low)
//
// state | meaning
// IDLE  | waiting for a request
// RD1   | SRAM read, EN/OE low
// RD2   | SRAM read, EN/OE low, bus captured at the end
// WR1   | SRAM write, EN/WE low, bus driven
// WR2   | SRAM write, WE released, bus held
// UW1   | UART write, wrn low, bus driven
// UW2   | UART write, wrn released, bus held
// UW3   | UART write, wait for tbre
// UW4   | UART write, wait for tsre
// UR0   | UART read, wait for data_ready
// UR1   | UART read, rdn low
// UR2   | UART read, rdn low, low byte captured at the end
// ST    | status access, status captured on reads
// DONE  | done pulse, all strobes inactive
module mem_bus_sequencer #(
    parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
    parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
    parameter int unsigned TIMEOUT        = 65535
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req,
    input  logic [1:0]  memRead,
    input  logic [1:0]  memWrite,
    input  logic [15:0] address,
    input  logic [15:0] dataIn,
    output logic [15:0] dataOut,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic        ram1OE,
    output logic        ram1WE,
    output logic        ram1EN,
    output logic [17:0] ram1Addr,
    inout  wire  [15:0] ram1Data,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    output logic        rdn,
    output logic        wrn
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD1, S_RD2, S_WR1, S_WR2, S_UW1, S_UW2, S_UW3,
        S_UW4, S_UR0, S_UR1, S_UR2, S_ST, S_DONE
    } state_t;

    // Counter value on the last permitted wait cycle.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [15:0] bus_q, bus_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic        terr_q, terr_d;
    logic        drive_q, drive_d;
    logic        oe_q, oe_d, we_q, we_d, en_q, en_d;
    logic        rdn_q, rdn_d, wrn_q, wrn_d;
    logic        done_q, done_d, busy_q, busy_d;
    logic        wait_expired;
    logic        is_wr;

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        wr_d         = wr_q;
        bus_d        = bus_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        terr_d       = terr_q;
        is_wr        = |memWrite;
        wait_expired = (TIMEOUT != 0) && (cnt_q == WAIT_LAST);

        unique case (state_q)
            S_IDLE: begin
                if (req && (|memRead || |memWrite)) begin
                    wr_d   = is_wr;
                    terr_d = 1'b0;
                    if (address == UART_DATA_ADDR) begin
                        state_d = is_wr ? S_UW1 : S_UR0;
                        bus_d   = {8'h00, dataIn[7:0]};
                    end else if (address == UART_STAT_ADDR) begin
                        state_d = S_ST;
                    end else begin
                        state_d = is_wr ? S_WR1 : S_RD1;
                        bus_d   = dataIn;
                        addr_d  = {2'b00, address};
                    end
                end
            end
            S_RD1: state_d = S_RD2;
            S_RD2: begin
                dout_d  = ram1Data;
                state_d = S_DONE;
            end
            S_WR1: state_d = S_WR2;
            S_WR2: state_d = S_DONE;
            S_UW1: state_d = S_UW2;
            S_UW2: state_d = S_UW3;
            S_UW3: begin
                if (tbre) begin
                    state_d = S_UW4;
                end else if (wait_expired) begin
                    state_d = S_DONE;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_UW4: begin
                if (tsre) begin
                    state_d = S_DONE;
                end else if (wait_expired) begin
                    state_d = S_DONE;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_UR0: begin
                if (data_ready) begin
                    state_d = S_UR1;
                end else if (wait_expired) begin
                    state_d = S_DONE;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_UR1: state_d = S_UR2;
            S_UR2: begin
                dout_d  = {8'h00, ram1Data[7:0]};
                state_d = S_DONE;
            end
            S_ST: begin
                // Writes to the status address complete without effect.
                if (!wr_q) begin
                    dout_d = {14'b0, data_ready, tbre & tsre};
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes are decoded from the next state so the registered outputs
        // line up with the state they belong to.
        oe_d    = !(state_d inside {S_RD1, S_RD2});
        en_d    = !(state_d inside {S_RD1, S_RD2, S_WR1, S_WR2});
        we_d    = !(state_d == S_WR1);
        wrn_d   = !(state_d == S_UW1);
        rdn_d   = !(state_d inside {S_UR1, S_UR2});
        drive_d = state_d inside {S_WR1, S_WR2, S_UW1, S_UW2};
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            bus_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            terr_q  <= 1'b0;
            drive_q <= 1'b0;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            en_q    <= 1'b1;
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            bus_q   <= bus_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            terr_q  <= terr_d;
            drive_q <= drive_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            en_q    <= en_d;
            rdn_q   <= rdn_d;
            wrn_q   <= wrn_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign ram1Data    = drive_q ? bus_q : 16'hzzzz;
    assign dataOut     = dout_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign ram1OE      = oe_q;
    assign ram1WE      = we_q;
    assign ram1EN      = en_q;
    assign ram1Addr    = addr_q;
    assign rdn         = rdn_q;
    assign wrn         = wrn_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
module tb_mem_bus_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST, req, req8;
    logic [1:0]  memRead, memWrite;
    logic [15:0] address, dataIn;
    logic        data_ready, tbre, tsre;
    logic        tbre_m, tsre_m, tbre_en, tsre_en;
    wire  [15:0] ram1Data;
    logic [15:0] dataOut, dataOut8;
    logic        busy, done, timeout_err, ram1OE, ram1WE, ram1EN, rdn, wrn;
    logic        busy8, done8, timeout_err8, ram1OE8, ram1WE8, ram1EN8, rdn8, wrn8;
    logic [17:0] ram1Addr, ram1Addr8;

    assign tbre = tbre_m & tbre_en;
    assign tsre = tsre_m & tsre_en;

    mem_bus_sequencer dut (
        .CLK(CLK), .RST(RST), .req(req), .memRead(memRead), .memWrite(memWrite),
        .address(address), .dataIn(dataIn), .dataOut(dataOut), .busy(busy),
        .done(done), .timeout_err(timeout_err), .ram1OE(ram1OE), .ram1WE(ram1WE),
        .ram1EN(ram1EN), .ram1Addr(ram1Addr), .ram1Data(ram1Data),
        .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .rdn(rdn), .wrn(wrn)
    );

    // Short-timeout instance; it only ever reads, so it never drives the bus.
    mem_bus_sequencer #(.TIMEOUT(8)) dut8 (
        .CLK(CLK), .RST(RST), .req(req8), .memRead(memRead), .memWrite(memWrite),
        .address(address), .dataIn(dataIn), .dataOut(dataOut8), .busy(busy8),
        .done(done8), .timeout_err(timeout_err8), .ram1OE(ram1OE8), .ram1WE(ram1WE8),
        .ram1EN(ram1EN8), .ram1Addr(ram1Addr8), .ram1Data(ram1Data),
        .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .rdn(rdn8), .wrn(wrn8)
    );

    // Peripheral models: SRAM array and UART byte source on the shared bus.
    logic [15:0] sram [0:1023];
    logic [7:0]  uart_rx;
    logic        tb_drv;
    logic [15:0] tb_val;

    always_comb begin
        tb_drv = 1'b0;
        tb_val = 16'h0000;
        if (!ram1EN && !ram1OE) begin
            tb_drv = 1'b1;
            tb_val = sram[ram1Addr[9:0]];
        end else if (!rdn) begin
            tb_drv = 1'b1;
            tb_val = {8'hA5, uart_rx};
        end
    end
    assign ram1Data = tb_drv ? tb_val : 16'hzzzz;

    always @(posedge CLK) begin
        if (!ram1EN && !ram1WE) sram[ram1Addr[9:0]] <= ram1Data;
    end

    // UART transmitter: flags drop when wrn is seen low and rise after the
    // configured number of cycles.
    int tx_tbre_dly = 1, tx_tsre_dly = 1, tx_cnt;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            tbre_m <= 1'b1;
            tsre_m <= 1'b1;
            tx_cnt <= 0;
        end else if (!wrn) begin
            tbre_m <= 1'b0;
            tsre_m <= 1'b0;
            tx_cnt <= 1;
        end else if (tx_cnt != 0) begin
            if (tx_cnt == tx_tbre_dly) tbre_m <= 1'b1;
            if (tx_cnt == tx_tsre_dly) tsre_m <= 1'b1;
            tx_cnt <= (tx_cnt >= 64) ? 0 : tx_cnt + 1;
        end
    end

    // Strobe activity monitor, sampled mid-cycle.
    int n_we, n_oe, n_en, n_wrn, n_rdn, n_rdn8;
    logic [15:0] we_bus, wrn_bus;
    initial begin
        n_we = 0; n_oe = 0; n_en = 0; n_wrn = 0; n_rdn = 0; n_rdn8 = 0;
        we_bus = '0; wrn_bus = '0;
    end
    always @(negedge CLK) begin
        if (!ram1WE) begin n_we <= n_we + 1; we_bus <= ram1Data; end
        if (!ram1OE) n_oe <= n_oe + 1;
        if (!ram1EN) n_en <= n_en + 1;
        if (!wrn) begin n_wrn <= n_wrn + 1; wrn_bus <= ram1Data; end
        if (!rdn) n_rdn <= n_rdn + 1;
        if (!rdn8) n_rdn8 <= n_rdn8 + 1;
    end

    int checks = 0, failures = 0;
    int s_we, s_oe, s_en, s_wrn, s_rdn, s_rdn8;

    // Reference model state.
    logic [15:0] exp_mem [logic [15:0]];
    logic [15:0] wr_addrs [$];
    logic [15:0] exp_dout;
    logic [17:0] exp_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_we = n_we; s_oe = n_oe; s_en = n_en; s_wrn = n_wrn; s_rdn = n_rdn; s_rdn8 = n_rdn8;
    endtask

    // Presents one request and returns the cycle (1 = first cycle after the
    // accept edge) in which done was seen. Optionally raises data_ready in
    // cycle rx_k.
    task automatic issue(input bit use8, input logic [1:0] mr, input logic [1:0] mw,
                         input logic [15:0] a, input logic [15:0] d, input int rx_k,
                         output int lat);
        int l;
        chk(use8 ? "busy8_at_req" : "busy_at_req", use8 ? busy8 : busy, 0);
        address = a; dataIn = d; memRead = mr; memWrite = mw;
        if (use8) req8 = 1'b1; else req = 1'b1;
        l = 0;
        fork
            begin
                @(posedge CLK); #1;
                req = 1'b0; req8 = 1'b0; memRead = 2'b00; memWrite = 2'b00;
                l = 1;
                while (!(use8 ? done8 : done) && l < 300) begin
                    @(posedge CLK); #1;
                    l++;
                end
            end
            begin
                if (rx_k > 0) begin
                    data_ready = 1'b0;
                    repeat (rx_k) @(posedge CLK);
                    #1 data_ready = 1'b1;
                end
            end
        join
        lat = l;
    endtask

    task automatic step_idle();
        @(posedge CLK); #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
    endtask

    task automatic sram_wr(input logic [15:0] a, input logic [15:0] d,
                           input logic [1:0] mr, input logic [1:0] mw);
        int lat;
        snap();
        issue(1'b0, mr, mw, a, d, 0, lat);
        exp_addr = {2'b00, a};
        chk("sram_wr_lat", lat, 3);
        chk("sram_wr_addr", ram1Addr, exp_addr);
        chk("sram_wr_dout", dataOut, exp_dout);
        step_idle();
        chk("sram_wr_we_cycles", n_we - s_we, 1);
        chk("sram_wr_bus", we_bus, d);
        chk("sram_wr_en_cycles", n_en - s_en, 2);
        chk("sram_wr_oe_cycles", n_oe - s_oe, 0);
        exp_mem[a] = d;
        wr_addrs.push_back(a);
    endtask

    task automatic sram_rd(input logic [15:0] a, input logic [1:0] mr);
        int lat;
        snap();
        issue(1'b0, mr, 2'b00, a, 16'h0000, 0, lat);
        exp_addr = {2'b00, a};
        exp_dout = exp_mem[a];
        chk("sram_rd_lat", lat, 3);
        chk("sram_rd_addr", ram1Addr, exp_addr);
        chk("sram_rd_dout", dataOut, exp_dout);
        step_idle();
        chk("sram_rd_oe_cycles", n_oe - s_oe, 2);
        chk("sram_rd_en_cycles", n_en - s_en, 2);
        chk("sram_rd_we_cycles", n_we - s_we, 0);
    endtask

    task automatic uart_wr(input logic [15:0] d, input int tbd, input int tsd,
                           input logic [1:0] mr, input logic [1:0] mw);
        int lat, tb_vis, ts_vis, uw4, exp_lat;
        tx_tbre_dly = tbd; tx_tsre_dly = tsd;
        // Flags become visible tbd+2 / tsd+2 cycles after accept; each wait
        // step takes at least one cycle and leaves the cycle after its flag.
        tb_vis  = tbd + 2;
        ts_vis  = tsd + 2;
        uw4     = ((tb_vis > 3) ? tb_vis : 3) + 1;
        exp_lat = ((ts_vis > uw4) ? ts_vis : uw4) + 1;
        snap();
        issue(1'b0, mr, mw, 16'hBF00, d, 0, lat);
        chk("uart_wr_lat", lat, exp_lat);
        chk("uart_wr_dout", dataOut, exp_dout);
        chk("uart_wr_addr_hold", ram1Addr, exp_addr);
        step_idle();
        chk("uart_wr_wrn_cycles", n_wrn - s_wrn, 1);
        chk("uart_wr_bus", wrn_bus, {8'h00, d[7:0]});
        chk("uart_wr_en_cycles", n_en - s_en, 0);
        chk("uart_wr_rdn_cycles", n_rdn - s_rdn, 0);
    endtask

    task automatic uart_rd(input logic [7:0] b, input int k, input logic [1:0] mr);
        int lat;
        uart_rx = b;
        if (k == 0) data_ready = 1'b1;
        snap();
        issue(1'b0, mr, 2'b00, 16'hBF00, 16'h0000, k, lat);
        exp_dout = {8'h00, b};
        chk("uart_rd_lat", lat, ((k > 1) ? k : 1) + 3);
        chk("uart_rd_dout", dataOut, exp_dout);
        step_idle();
        chk("uart_rd_rdn_cycles", n_rdn - s_rdn, 2);
        chk("uart_rd_en_cycles", n_en - s_en, 0);
        chk("uart_rd_wrn_cycles", n_wrn - s_wrn, 0);
    endtask

    task automatic stat_rd(input logic dr, input logic tb, input logic ts, input logic [1:0] mr);
        int lat;
        data_ready = dr; tbre_en = tb; tsre_en = ts;
        snap();
        issue(1'b0, mr, 2'b00, 16'hBF01, 16'h0000, 0, lat);
        exp_dout = {14'b0, dr, tb & ts};
        chk("stat_rd_lat", lat, 2);
        chk("stat_rd_dout", dataOut, exp_dout);
        step_idle();
        chk("stat_rd_en_cycles", n_en - s_en, 0);
        tbre_en = 1'b1; tsre_en = 1'b1;
    endtask

    task automatic stat_wr(input logic [15:0] d, input logic [1:0] mw);
        int lat;
        snap();
        issue(1'b0, 2'b00, mw, 16'hBF01, d, 0, lat);
        chk("stat_wr_lat", lat, 2);
        chk("stat_wr_dout", dataOut, exp_dout);
        step_idle();
        chk("stat_wr_strobes", (n_we - s_we) + (n_en - s_en) + (n_wrn - s_wrn) + (n_rdn - s_rdn), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int kind;
        logic [15:0] a, d;

        RST = 1'b1; req = 1'b0; req8 = 1'b0; memRead = 2'b00; memWrite = 2'b00;
        address = 16'h0000; dataIn = 16'h0000; data_ready = 1'b0;
        tbre_en = 1'b1; tsre_en = 1'b1; uart_rx = 8'h00;
        exp_dout = 16'h0000; exp_addr = 18'h0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        #1;

        // Reset state
        chk("rst_oe", ram1OE, 1); chk("rst_we", ram1WE, 1); chk("rst_en", ram1EN, 1);
        chk("rst_rdn", rdn, 1);   chk("rst_wrn", wrn, 1);
        chk("rst_addr", ram1Addr, 0); chk("rst_dout", dataOut, 0);
        chk("rst_done", done, 0); chk("rst_busy", busy, 0); chk("rst_terr", timeout_err, 0);
        chk("rst8_strobes", {ram1OE8, ram1WE8, ram1EN8, wrn8, rdn8}, 5'h1F);
        chk("rst8_addr", ram1Addr8, 0); chk("rst8_busy", busy8, 0);

        // Request with both access fields zero is ignored
        @(posedge CLK); #1;
        address = 16'h0010; req = 1'b1;
        @(posedge CLK); #1;
        req = 1'b0;
        chk("zero_req_busy", busy, 0);
        chk("zero_req_en", ram1EN, 1);

        // SRAM write then read back
        sram_wr(16'h0123, 16'hBEEF, 2'b00, 2'b01);
        chk("sram_addr_0123", ram1Addr, 18'h00123);
        sram_rd(16'h0123, 2'b01);

        // UART write: tbre 4 and tsre 6 cycles after wrn falls
        uart_wr(16'h1241, 3, 5, 2'b00, 2'b01);

        // UART read blocked for 10 cycles
        uart_rd(8'h5A, 11, 2'b01);
        chk("uart_rd_5a", dataOut, 16'h005A);

        // Status read with RX ready, TX busy
        stat_rd(1'b1, 1'b1, 1'b0, 2'b01);
        chk("stat_0002", dataOut, 16'h0002);
        stat_wr(16'hFFFF, 2'b11);

        // req held high while busy: only one access results
        snap();
        address = 16'h0044; dataIn = 16'h4444; memWrite = 2'b01; req = 1'b1;
        @(posedge CLK); #1;
        address = 16'h0200; dataIn = 16'h1111; memWrite = 2'b10;
        repeat (3) @(posedge CLK);
        #1 req = 1'b0; memWrite = 2'b00;
        repeat (3) @(posedge CLK);
        #1;
        chk("busy_req_we_cycles", n_we - s_we, 1);
        chk("busy_req_bus", we_bus, 16'h4444);
        chk("busy_req_addr", ram1Addr, 18'h00044);
        chk("busy_req_idle", busy, 0);
        exp_mem[16'h0044] = 16'h4444; wr_addrs.push_back(16'h0044); exp_addr = 18'h00044;

        // Timeout on the TIMEOUT=8 instance
        data_ready = 1'b0;
        snap();
        issue(1'b1, 2'b01, 2'b00, 16'hBF00, 16'h0000, 0, lat);
        chk("to_lat", lat, 9);
        chk("to_err", timeout_err8, 1);
        chk("to_dout", dataOut8, 0);
        @(posedge CLK); #1;
        chk("to_err_sticky", timeout_err8, 1);
        chk("to_rdn_cycles", n_rdn8 - s_rdn8, 0);
        data_ready = 1'b1;
        issue(1'b1, 2'b01, 2'b00, 16'hBF01, 16'h0000, 0, lat);
        chk("to_clear_lat", lat, 2);
        chk("to_err_cleared", timeout_err8, 0);
        chk("to_clear_dout", dataOut8, 16'h0003);
        @(posedge CLK); #1;

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: begin
                    a = 16'($urandom_range(0, 1023));
                    d = 16'($urandom);
                    sram_wr(a, d, 2'($urandom_range(0, 3)), 2'($urandom_range(1, 3)));
                end
                1: sram_rd(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)], 2'($urandom_range(1, 3)));
                2: uart_wr(16'($urandom), $urandom_range(1, 6), $urandom_range(1, 8),
                           2'($urandom_range(0, 3)), 2'($urandom_range(1, 3)));
                3: uart_rd(8'($urandom), $urandom_range(0, 7), 2'($urandom_range(1, 3)));
                4: stat_rd(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom_range(1, 3)));
                default: stat_wr(16'($urandom), 2'($urandom_range(1, 3)));
            endcase
        end

        // Reset in the middle of an SRAM write
        address = 16'h0321; dataIn = 16'h7777; memWrite = 2'b01; req = 1'b1;
        @(posedge CLK); #1;
        req = 1'b0; memWrite = 2'b00;
        chk("mid_pre_we", ram1WE, 0);
        chk("mid_pre_en", ram1EN, 0);
        #1 RST = 1'b1;
        #1;
        chk("mid_rst_we", ram1WE, 1);
        chk("mid_rst_en", ram1EN, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_dout", dataOut, 0);
        chk("mid_rst_addr", ram1Addr, 0);
        #1 RST = 1'b0;
        exp_dout = 16'h0000; exp_addr = 18'h0;
        @(posedge CLK); #1;
        chk("post_rst_busy", busy, 0);
        sram_rd(wr_addrs[0], 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
